// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the nibble-serial CLA sequencer.
package cla_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned NIBBLE_W = 4;

  function automatic int unsigned nib_count(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

  function automatic int unsigned idx_width(input int unsigned nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit generate/propagate carry-look-ahead adder slice.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products back to cin; no ripple between bits.
  assign c[0] = g[0] | (p[0] & cin);
  assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ {c[2:0], cin};
  assign cout = c[3];

endmodule

// File: rtl/cla_share_seq.sv
// Round-robin sequencer pushing WIDTH-bit adds nibble by nibble through one shared CLA slice.
module cla_share_seq
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);

  localparam int unsigned NIB  = nib_count(WIDTH);
  localparam int unsigned IDXW = idx_width(NIB);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              id_q, id_d;
  logic              last_id_q, last_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_sum_q, rsp_sum_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic              rsp_id_q, rsp_id_d;

  logic              idle;
  logic              grant0;
  logic              grant1;
  logic [IDXW+1:0]   nib_sh;
  logic [3:0]        slice_a;
  logic [3:0]        slice_b;
  logic [3:0]        slice_sum;
  logic              slice_cout;
  logic [WIDTH-1:0]  nib_mask;
  logic [WIDTH-1:0]  sum_ext;

  // Under contention the requester that did not win last time goes first.
  assign idle   = (state_q == ST_IDLE) && !rst;
  assign grant0 = req0_valid && (!req1_valid || last_id_q);
  assign grant1 = req1_valid && (!req0_valid || !last_id_q);

  assign req0_ready = idle && grant0;
  assign req1_ready = idle && grant1;

  assign nib_sh   = {idx_q, 2'b00};
  assign slice_a  = NIBBLE_W'(a_q >> nib_sh);
  assign slice_b  = NIBBLE_W'(b_q >> nib_sh);
  assign nib_mask = WIDTH'(4'hF) << nib_sh;
  assign sum_ext  = WIDTH'(slice_sum) << nib_sh;

  cla4_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    id_d        = id_q;
    last_id_d   = last_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;

    case (state_q)
      ST_IDLE: begin
        if (req0_ready || req1_ready) begin
          a_d       = req1_ready ? req1_a   : req0_a;
          b_d       = req1_ready ? req1_b   : req0_b;
          carry_d   = req1_ready ? req1_cin : req0_cin;
          idx_d     = '0;
          id_d      = req1_ready;
          last_id_d = req1_ready;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d   = (res_q & ~nib_mask) | sum_ext;
        carry_d = slice_cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NIB - 1)) begin
          idx_d       = '0;
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_sum_d   = res_d;
          rsp_cout_d  = slice_cout;
          rsp_id_d    = id_q;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      id_q        <= 1'b0;
      last_id_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      id_q        <= id_d;
      last_id_q   <= last_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_cla_share_seq.sv
// Directed bench for cla_share_seq with a cycle-level transaction model and per-cycle compare.
module tb_cla_share_seq;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req0_cin;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready, req1_cin;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [WIDTH-1:0] rsp_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_share_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: busy countdown of NIB cycles, then a held response.
  int               m_cnt;
  bit               m_last, m_valid, m_id, m_cout, m_g;
  bit               p_id, p_cout;
  logic [WIDTH-1:0] m_sum, p_sum;
  logic [WIDTH:0]   m_full;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_last = 1'b1; m_valid = 1'b0;
      m_sum = '0; m_cout = 1'b0; m_id = 1'b0;
    end else if (m_valid) begin
      if (rsp_ready) m_valid = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1'b1; m_sum = p_sum; m_cout = p_cout; m_id = p_id;
      end
    end else if (req0_valid || req1_valid) begin
      m_g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
      m_full = m_g ? ({1'b0, req1_a} + req1_b + req1_cin)
                   : ({1'b0, req0_a} + req0_b + req0_cin);
      p_sum  = m_full[WIDTH-1:0];
      p_cout = m_full[WIDTH];
      p_id   = m_g;
      m_last = m_g;
      m_cnt  = NIB;
    end
  end

  bit c_idle, c_e0, c_e1;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_sum", rsp_sum, 0);
      chk("rst_cout", rsp_cout, 0);
      chk("rst_id", rsp_id, 0);
    end else begin
      c_idle = !m_valid && (m_cnt == 0);
      c_e0   = c_idle && req0_valid && (!req1_valid || m_last);
      c_e1   = c_idle && req1_valid && (!req0_valid || !m_last);
      chk("cyc_ready0", req0_ready, c_e0);
      chk("cyc_ready1", req1_ready, c_e1);
      chk("cyc_valid", rsp_valid, m_valid);
      if (m_valid) begin
        chk("cyc_sum", rsp_sum, m_sum);
        chk("cyc_cout", rsp_cout, m_cout);
        chk("cyc_id", rsp_id, m_id);
      end
    end
  end

  // Caller is at posedge+1 with the DUT idle. hold = cycles of rsp_ready low in DONE.
  task automatic do_add(input string nm, input bit r, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input bit ci,
                        input logic [WIDTH-1:0] es, input bit ec, input int hold);
    bit got;
    int lat;
    logic [WIDTH-1:0] s0;
    if (r) begin req1_valid = 1; req1_a = a; req1_b = b; req1_cin = ci; end
    else   begin req0_valid = 1; req0_a = a; req0_b = b; req0_cin = ci; end
    got = 0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (r ? req1_ready : req0_ready) begin got = 1; break; end
      @(posedge clk); #1;
    end
    chk({nm, "_accept"}, 32'(got), 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    req0_a = 16'($urandom); req0_b = 16'($urandom);
    req1_a = 16'($urandom); req1_b = 16'($urandom);
    got = 0; lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); lat++; #1;
      if (rsp_valid) begin got = 1; break; end
    end
    chk({nm, "_lat"}, 32'(lat), NIB);
    chk({nm, "_sum"}, rsp_sum, es);
    chk({nm, "_cout"}, rsp_cout, ec);
    chk({nm, "_id"}, rsp_id, r);
    chk({nm, "_model"}, {m_cout, m_sum}, {ec, es});
    s0 = rsp_sum;
    if (hold > 0) begin
      req0_valid = 1; req1_valid = 1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #2;
        chk({nm, "_hold_valid"}, rsp_valid, 1);
        chk({nm, "_hold_sum"}, rsp_sum, s0);
        chk({nm, "_hold_rdy"}, {req0_ready, req1_ready}, 0);
      end
    end
    rsp_ready = 1; req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk({nm, "_released"}, rsp_valid, 0);
  endtask

  int g_id[$];
  int g_cyc[$];
  bit got;

  initial begin
    rst = 1; rsp_ready = 0;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0;
    repeat (3) @(posedge clk);
    #1 req0_valid = 1;
    #1 chk("reset_ready0", req0_ready, 0);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_sum", rsp_sum, 0);
    req0_valid = 0;
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;

    do_add("single",  0, 16'h1234, 16'h4321, 0, 16'h5555, 0, 0);
    do_add("ripple",  0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0);
    do_add("ripple1", 1, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 0);
    do_add("cin_a",   0, 16'hFFFF, 16'h0000, 1, 16'h0000, 1, 0);
    do_add("cin_b",   1, 16'h0F0F, 16'hF0F0, 1, 16'h0000, 1, 0);
    do_add("bp",      0, 16'h1111, 16'h2222, 1, 16'h3334, 0, 5);

    // Contention straight out of reset: both valid, consumer always ready.
    @(posedge clk); #1;
    rst = 1; rsp_ready = 1;
    req0_valid = 1; req0_a = 16'h00FF; req0_b = 16'h0001; req0_cin = 0;
    req1_valid = 1; req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1;
    @(posedge clk); #1 rst = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req0_ready) begin g_id.push_back(0); g_cyc.push_back(c); end
      if (req1_ready) begin g_id.push_back(1); g_cyc.push_back(c); end
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;
    chk("cont_count", g_id.size(), 4);
    for (int i = 0; i < g_id.size() && i < 4; i++) begin
      chk("cont_grant", g_id[i], i % 2);
      if (i > 0) chk("cont_spacing", g_cyc[i] - g_cyc[i-1], NIB + 2);
    end
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (!m_valid && m_cnt == 0 && !rsp_valid) begin got = 1; break; end
    end
    chk("cont_drain", 32'(got), 1);
    rsp_ready = 0;

    // Reset while the slice is on nibble 2.
    req0_valid = 1; req0_a = 16'h0FFF; req0_b = 16'h0001; req0_cin = 0;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (req0_ready) begin got = 1; break; end
      @(posedge clk); #1;
    end
    chk("mid_accept", 32'(got), 1);
    @(posedge clk); #1 req0_valid = 0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1;
    #1;
    chk("mid_valid", rsp_valid, 0);
    chk("mid_sum", rsp_sum, 0);
    chk("mid_rdy", {req0_ready, req1_ready}, 0);
    req0_valid = 1; req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 0;
    req1_valid = 1; req1_a = 16'h0010; req1_b = 16'h0020; req1_cin = 0;
    @(posedge clk); #1 rst = 0;
    #1;
    chk("post_rdy", {req0_ready, req1_ready}, 2'b10);
    chk("post_valid", rsp_valid, 0);
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin chk("post_lat", k + 1, NIB); got = 1; break; end
    end
    chk("post_rsp", 32'(got), 1);
    chk("post_sum", rsp_sum, 16'h0003);
    chk("post_id", rsp_id, 0);
    rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
